// File: rtl/bmp_frame_writer.sv
// Captures one RGB pixel-stream frame into an internal buffer, then streams it
// back out as a complete 24-bpp bottom-up BMP file over a valid/ready byte port.
module bmp_frame_writer #(
  parameter int MAX_WIDTH  = 1080,
  parameter int MAX_HEIGHT = 1080,
  parameter int PPM        = 2835
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        pix_valid,
  input  logic [31:0] in_width,
  input  logic [31:0] in_height,
  input  logic [10:0] in_row,
  input  logic [10:0] in_col,
  input  logic [7:0]  in_r,
  input  logic [7:0]  in_g,
  input  logic [7:0]  in_b,
  input  logic        in_done,
  output logic [7:0]  out_byte,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        busy,
  output logic        err_dim,
  output logic        err_overrun
);
  localparam int DEPTH = MAX_WIDTH * MAX_HEIGHT;
  localparam int AW    = $clog2(DEPTH);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CAP  = 3'd1,
    HDR  = 3'd2,
    PIX  = 3'd3,
    PAD  = 3'd4
  } state_t;

  state_t      state_r;
  logic [31:0] w_r, h_r;
  logic [5:0]  hdr_idx_r;
  logic [31:0] col_r, row_cnt_r;
  logic [31:0] rd_addr_r, rd_col_r;
  logic [1:0]  comp_r, pad_left_r;
  logic [15:0] cur_gb_r;
  logic [23:0] rd_data_r;
  logic [23:0] mem_r [0:DEPTH-1];
  logic [7:0]  out_byte_r;
  logic        out_valid_r, out_last_r, busy_r, err_dim_r, err_overrun_r;

  logic [31:0] geo_w_s, geo_h_s, rb_s, img_size_s, file_size_s;
  logic [31:0] rd_addr_nxt_s, rd_col_nxt_s;
  logic [AW-1:0] wr_idx_s, rd_idx_s;
  logic        dim_bad_s, in_range_s, wr_en_s, xfer_s, last_row_s, last_col_s;
  logic [1:0]  pad_n_s;
  logic [7:0]  hdr_next_s;

  assign out_byte    = out_byte_r;
  assign out_valid   = out_valid_r;
  assign out_last    = out_last_r;
  assign busy        = busy_r;
  assign err_dim     = err_dim_r;
  assign err_overrun = err_overrun_r;

  // Header fields are grouped into 32-bit words starting at byte 2; the two
  // u16 fields (planes, bpp) pack into one such word.
  function automatic logic [7:0] hdr_byte(input logic [5:0] idx, input logic [31:0] w,
                                          input logic [31:0] h, input logic [31:0] img,
                                          input logic [31:0] fsize);
    logic [5:0]  rel;
    logic [31:0] word;
    rel = idx - 6'd2;
    case (rel[5:2])
      4'd0:        word = fsize;
      4'd2:        word = 32'd54;
      4'd3:        word = 32'd40;
      4'd4:        word = w;
      4'd5:        word = h;
      4'd6:        word = 32'h0018_0001;
      4'd8:        word = img;
      4'd9, 4'd10: word = 32'(PPM);
      default:     word = 32'd0;
    endcase
    case (idx)
      6'd0:    hdr_byte = 8'h42;
      6'd1:    hdr_byte = 8'h4D;
      default: hdr_byte = word[{rel[1:0], 3'b000} +: 8];
    endcase
  endfunction

  // Geometry, write decode and next-byte helpers.
  always_comb begin
    geo_w_s    = (state_r == IDLE) ? in_width : w_r;
    geo_h_s    = (state_r == IDLE) ? in_height : h_r;
    dim_bad_s  = (in_width == 32'd0) || (in_height == 32'd0) ||
                 (in_width > 32'(MAX_WIDTH)) || (in_height > 32'(MAX_HEIGHT));
    in_range_s = ({21'd0, in_row} < geo_h_s) && ({21'd0, in_col} < geo_w_s);
    wr_idx_s   = AW'({21'd0, in_row} * geo_w_s + {21'd0, in_col});
    if (pix_valid && in_range_s) begin
      if (state_r == IDLE) begin
        wr_en_s = !dim_bad_s;
      end else begin
        wr_en_s = (state_r == CAP);
      end
    end else begin
      wr_en_s = 1'b0;
    end
    rb_s        = ((w_r * 32'd3) + 32'd3) & ~32'd3;
    img_size_s  = rb_s * h_r;
    file_size_s = img_size_s + 32'd54;
    pad_n_s     = 2'(rb_s - (w_r * 32'd3));
    last_row_s  = (row_cnt_r == h_r - 32'd1);
    last_col_s  = (col_r == w_r - 32'd1);
    xfer_s      = out_valid_r && out_ready;
    hdr_next_s  = hdr_byte(hdr_idx_r + 6'd1, w_r, h_r, img_size_s, file_size_s);
    rd_idx_s    = (rd_addr_r < 32'(DEPTH)) ? rd_addr_r[AW-1:0] : {AW{1'b0}};
    // Read pointer walks a row left to right, then jumps to the start of the row above.
    if (rd_col_r == w_r - 32'd1) begin
      rd_addr_nxt_s = rd_addr_r + 32'd1 - (w_r << 1);
      rd_col_nxt_s  = 32'd0;
    end else begin
      rd_addr_nxt_s = rd_addr_r + 32'd1;
      rd_col_nxt_s  = rd_col_r + 32'd1;
    end
  end

  // Frame buffer: one write port from the pixel stream, one registered read port.
  always_ff @(posedge CLK) begin
    if (wr_en_s) begin
      mem_r[wr_idx_s] <= {in_r, in_g, in_b};
    end
    rd_data_r <= mem_r[rd_idx_s];
  end

  // Capture/stream FSM. Counters describe the byte currently on out_byte; the
  // read pointer always runs one pixel ahead so every R byte is ready in time.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_r       <= IDLE;
      w_r           <= 32'd0;
      h_r           <= 32'd0;
      hdr_idx_r     <= 6'd0;
      col_r         <= 32'd0;
      row_cnt_r     <= 32'd0;
      rd_addr_r     <= 32'd0;
      rd_col_r      <= 32'd0;
      comp_r        <= 2'd0;
      pad_left_r    <= 2'd0;
      cur_gb_r      <= 16'd0;
      out_byte_r    <= 8'd0;
      out_valid_r   <= 1'b0;
      out_last_r    <= 1'b0;
      busy_r        <= 1'b0;
      err_dim_r     <= 1'b0;
      err_overrun_r <= 1'b0;
    end else begin
      if (pix_valid && busy_r) begin
        err_overrun_r <= 1'b1;
      end
      case (state_r)
        IDLE: begin
          if (pix_valid) begin
            if (dim_bad_s) begin
              err_dim_r <= 1'b1;
            end else begin
              w_r     <= in_width;
              h_r     <= in_height;
              state_r <= CAP;
            end
          end
        end
        CAP: begin
          if (in_done) begin
            state_r     <= HDR;
            busy_r      <= 1'b1;
            out_valid_r <= 1'b1;
            out_byte_r  <= 8'h42;
            out_last_r  <= 1'b0;
            hdr_idx_r   <= 6'd0;
            rd_addr_r   <= (h_r - 32'd1) * w_r;
            rd_col_r    <= 32'd0;
          end
        end
        HDR: begin
          if (xfer_s) begin
            if (hdr_idx_r != 6'd53) begin
              hdr_idx_r  <= hdr_idx_r + 6'd1;
              out_byte_r <= hdr_next_s;
            end else begin
              state_r    <= PIX;
              row_cnt_r  <= 32'd0;
              col_r      <= 32'd0;
              comp_r     <= 2'd0;
              out_byte_r <= rd_data_r[23:16];
              cur_gb_r   <= rd_data_r[15:0];
              rd_addr_r  <= rd_addr_nxt_s;
              rd_col_r   <= rd_col_nxt_s;
            end
          end
        end
        PIX: begin
          if (xfer_s) begin
            if (out_last_r) begin
              state_r     <= IDLE;
              out_valid_r <= 1'b0;
              out_last_r  <= 1'b0;
              out_byte_r  <= 8'd0;
              busy_r      <= 1'b0;
            end else if (comp_r != 2'd2) begin
              comp_r     <= comp_r + 2'd1;
              out_byte_r <= (comp_r == 2'd0) ? cur_gb_r[15:8] : cur_gb_r[7:0];
              out_last_r <= (comp_r == 2'd1) && last_col_s && last_row_s && (pad_n_s == 2'd0);
            end else if (last_col_s && (pad_n_s != 2'd0)) begin
              state_r    <= PAD;
              out_byte_r <= 8'd0;
              pad_left_r <= pad_n_s - 2'd1;
              out_last_r <= last_row_s && (pad_n_s == 2'd1);
            end else begin
              row_cnt_r  <= last_col_s ? row_cnt_r + 32'd1 : row_cnt_r;
              col_r      <= last_col_s ? 32'd0 : col_r + 32'd1;
              comp_r     <= 2'd0;
              out_byte_r <= rd_data_r[23:16];
              cur_gb_r   <= rd_data_r[15:0];
              rd_addr_r  <= rd_addr_nxt_s;
              rd_col_r   <= rd_col_nxt_s;
            end
          end
        end
        PAD: begin
          if (xfer_s) begin
            if (out_last_r) begin
              state_r     <= IDLE;
              out_valid_r <= 1'b0;
              out_last_r  <= 1'b0;
              out_byte_r  <= 8'd0;
              busy_r      <= 1'b0;
            end else if (pad_left_r != 2'd0) begin
              pad_left_r <= pad_left_r - 2'd1;
              out_byte_r <= 8'd0;
              out_last_r <= last_row_s && (pad_left_r == 2'd1);
            end else begin
              state_r    <= PIX;
              row_cnt_r  <= row_cnt_r + 32'd1;
              col_r      <= 32'd0;
              comp_r     <= 2'd0;
              out_byte_r <= rd_data_r[23:16];
              cur_gb_r   <= rd_data_r[15:0];
              rd_addr_r  <= rd_addr_nxt_s;
              rd_col_r   <= rd_col_nxt_s;
            end
          end
        end
        default: begin
          state_r     <= IDLE;
          out_valid_r <= 1'b0;
          out_last_r  <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: doc/bmp_frame_writer.md
Name: bmp_frame_writer

Overview:
- Downstream stage of the image processing block. Captures one processed frame from its pixel stream (row, col, R, G, B, frame dimensions) into an internal frame buffer.
- On frame completion, serializes a complete 24-bpp BMP file as a byte stream with valid/ready handshake, for the testbench file dumper or a DMA/UART sink.
- BMP header is built from the captured dimensions, so rotated frames (width/height swapped) are emitted correctly.

Parameters:
- MAX_WIDTH, 1080, maximum accepted frame width in pixels.
- MAX_HEIGHT, 1080, maximum accepted frame height in pixels.
- PPM, 2835, pixels-per-metre value written to both resolution header fields.

Ports:
- CLK  in  1  clock
- RESET  in  1  reset, asynchronous, active-low
- pix_valid  in  1  pixel beat valid (no backpressure on the input side)
- in_width  in  32  frame width, stable for the whole frame
- in_height  in  32  frame height, stable for the whole frame
- in_row  in  11  pixel row index, 0 = top
- in_col  in  11  pixel column index
- in_r / in_g / in_b  in  8 each  pixel components
- in_done  in  1  frame-complete flag, level or pulse
- out_byte  out  8  BMP byte
- out_valid  out  1  out_byte valid
- out_ready  in  1  sink accepts byte
- out_last  out  1  high with the final byte of the file
- busy  out  1  high in HDR, PIX or PAD
- err_dim  out  1  sticky: dimension 0 or out of range
- err_overrun  out  1  sticky: pix_valid seen while busy

Behaviour:
- Reset (async, RESET=0): state IDLE, out_byte=0, out_valid=0, out_last=0, busy=0, err_dim=0, err_overrun=0, all counters 0. Frame buffer contents are not reset.
- States: IDLE -> CAP -> HDR -> PIX <-> PAD -> IDLE.
- IDLE to CAP:
  - On the first pix_valid, latch W=in_width and H=in_height.
  - If W=0, H=0, W>MAX_WIDTH or H>MAX_HEIGHT: set err_dim, drop the beat, stay IDLE.
  - Otherwise write the beat and go to CAP.
- CAP:
  - Each pix_valid writes {R,G,B} to buffer[in_row*W+in_col].
  - Beats with in_row>=H or in_col>=W are dropped.
  - Duplicate addresses: last write wins. Unwritten pixels emit undefined data.
- CAP to HDR: on the first cycle with in_done=1. A pix_valid in that same cycle is still written.
- HDR:
  - Emits 54 header bytes, all multi-byte fields little-endian.
  - Byte 0 = 0x42, byte 1 = 0x4D.
  - File size (u32) = 54 + RB*H, where RB = (3W+3) & ~3.
  - Reserved (u32) = 0; data offset (u32) = 54; DIB size (u32) = 40.
  - Width (u32) = W; height (u32) = H (positive, i.e. bottom-up).
  - Planes (u16) = 1; bpp (u16) = 24; compression (u32) = 0.
  - Image size (u32) = RB*H; X ppm (u32) = PPM; Y ppm (u32) = PPM.
  - Colours used (u32) = 0; important colours (u32) = 0.
- PIX:
  - Rows are emitted bottom-up: row H-1 first, row 0 last.
  - Within a row, col 0..W-1; each pixel emits 3 bytes in order R, G, B, matching the team's reader convention of offset +0 = R.
- PAD: after each row, emit RB-3W zero bytes (0..3). When none are needed PAD is skipped. After the last row's padding, go to IDLE.
- Handshake:
  - A byte transfers when out_valid & out_ready.
  - While out_valid & !out_ready, out_byte and out_last are held stable.
  - out_valid never drops once asserted until the transfer.
  - The first header byte has out_valid=1 on the cycle after in_done is sampled.
  - With out_ready held high, no bubbles: total bytes = 54 + RB*H in exactly that many cycles. The implementation must prefetch buffer reads to achieve this.
- out_last = 1 only on byte 54+RB*H-1. The cycle after it transfers: out_valid=0, busy=0, state IDLE.
- pix_valid in HDR/PIX/PAD: ignored, sets err_overrun; the stream is unaffected.
- in_done while in IDLE: ignored.
- Error clearing: err_dim and err_overrun clear only on reset.
- Arithmetic: address and size computations use 32-bit unsigned; the pixel counter is sized for MAX_WIDTH*MAX_HEIGHT.
- Reset mid-operation: the stream aborts immediately (out_valid=0) and the next frame starts from IDLE.

Test Plan:
- 2x2 frame, pixels (r,c)->{16r+c, 0x80, 0xFF-c}, in_done, ready=1:
  - 70 bytes total; bytes 2..5 = 46 00 00 00; bytes 18..21 = 02 00 00 00.
  - Data = row1 px0, row1 px1, 00 00, row0 px0, row0 px1, 00 00.
  - out_last on byte 69.
- 4x1 frame: RB=12, no PAD bytes, file size 66 (0x42), 66 contiguous valid cycles with ready=1.
- Backpressure on a 3x2 frame (RB=12): toggle out_ready pseudo-randomly.
  - Byte sequence is identical to the ready=1 run.
  - out_byte stays stable while stalled; exactly 78 transfers.
- in_width=2000 on the first beat: err_dim=1, no output, state IDLE. A subsequent valid 1x1 frame still produces 58 bytes.
- pix_valid pulsed during HDR: err_overrun=1, output bytes unchanged.
- RESET asserted at header byte 20: out_valid=0 immediately. After release, a new 2x2 frame emits a full 70-byte file.
